// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
// Shared sizing, types and helpers for the SRAM access arbiter.
//   NUM_REQ / NUM_BANKS / ADDR_W / DATA_W : interface sizing
//   req_id_t    : requester port index
//   bank_t      : SRAM bank index
//   arb_state_t : arbitration FSM state {ARB, LOCKED}
//   rd_tag_t    : per-read tag carried down the read-return pipeline
// -----------------------------------------------------------------------------
package sram_arb_pkg;

  localparam int NUM_REQ   = 3;
  localparam int NUM_BANKS = 8;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 64;

  localparam int REQ_ID_W  = $clog2(NUM_REQ);
  localparam int BANK_W    = $clog2(NUM_BANKS);

  typedef logic [REQ_ID_W-1:0] req_id_t;
  typedef logic [BANK_W-1:0]   bank_t;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
    bank_t   bank;
  } rd_tag_t;

  // Cyclic successor of a port index.
  function automatic req_id_t next_id(req_id_t id);
    return (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
  endfunction

endpackage

// File: rtl/sram_rr_select.sv
// -----------------------------------------------------------------------------
// sram_rr_select
// Round-robin picker: grants the first set bit of 'valid' found searching
// cyclically upward from 'ptr'.
//   valid : candidate vector
//   ptr   : highest-priority index
//   grant : one-hot winner (all zero when no candidate)
// -----------------------------------------------------------------------------
module sram_rr_select #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant
);

  // Walk the search order backwards so the earliest candidate is written
  // last and wins, without needing a found flag.
  always_comb begin
    // NOTE: every always_comb output gets a default first; without it, a path
    // that skips the assignment infers a latch.
    grant = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int unsigned idx;
      idx = (int'(ptr) + k) % NUM_REQ;
      if (valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// -----------------------------------------------------------------------------
// sram_access_arbiter
// Arbitrates NUM_REQ requester ports onto a banked SRAM. Round-robin between
// ports, with an optional locked burst of up to MAX_BURST grants to one port.
// Strobes are registered one cycle after the handshake; read data is sampled
// RD_LAT cycles after the strobe and returned one cycle later to the issuer.
//   clk, n_rst            : clock, async active-low reset
//   req_valid/write/lock  : per-port request, direction, burst lock
//   req_bank/addr/wdata   : per-port flattened bank, word address, write data
//   req_ready             : one-hot grant (transfer = valid & ready at edge)
//   sram_cs/r/w_trigger   : one-hot per-bank select and strobes
//   sram_addr/wdata       : address and write data to SRAM
//   sram_rdata            : flattened per-bank read data
//   rsp_valid/rsp_data    : read response strobe (per port) and data
//   busy                  : request pending or read in flight
// -----------------------------------------------------------------------------
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ-1:0]          req_lock,
  input  logic [NUM_REQ*BANK_W-1:0]   req_bank,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_BANKS-1:0]        sram_cs,
  output logic [NUM_BANKS-1:0]        sram_r_trigger,
  output logic [NUM_BANKS-1:0]        sram_w_trigger,
  output logic [ADDR_W-1:0]           sram_addr,
  output logic [DATA_W-1:0]           sram_wdata,
  input  logic [NUM_BANKS*DATA_W-1:0] sram_rdata,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t         state_q, state_d;
  req_id_t            owner_q, owner_d;
  req_id_t            rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

  logic [NUM_REQ-1:0] owner_mask;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic               xfer;
  req_id_t            xfer_id;
  bank_t              xfer_bank;
  logic [NUM_BANKS-1:0] bank_oh;

  rd_tag_t            pipe_q [RD_LAT+1];
  logic               pipe_busy;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ARB;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values, independent of statement order.
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;

    if (xfer) rr_ptr_d = next_id(xfer_id);

    case (state_q)
      ARB: begin
        // A one-grant burst limit makes locking meaningless; stay in ARB.
        if (xfer && req_lock[xfer_id] && (MAX_BURST > 1)) begin
          state_d     = LOCKED;
          owner_d     = xfer_id;
          burst_cnt_d = CNT_W'(1);
        end
      end
      LOCKED: begin
        if (!req_valid[owner_q]) begin
          state_d     = ARB;
          burst_cnt_d = '0;
          rr_ptr_d    = next_id(owner_q);
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (!req_lock[owner_q] || (burst_cnt_d == CNT_W'(MAX_BURST))) begin
            state_d     = ARB;
            burst_cnt_d = '0;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM outputs: eligibility and grant
  // ---------------------------------------------------------------------------
  always_comb begin
    owner_mask          = '0;
    owner_mask[owner_q] = 1'b1;
    // Gating with n_rst keeps req_ready low for the whole reset assertion,
    // not just from the first clock edge.
    eligible = n_rst ? req_valid : '0;
    if (state_q == LOCKED) eligible = eligible & owner_mask;
  end

  sram_rr_select #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_select (
    .valid (eligible),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  assign req_ready = grant;
  assign xfer      = |grant;

  always_comb begin
    xfer_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) xfer_id = req_id_t'(i);
    end
    xfer_bank        = req_bank[xfer_id*BANK_W +: BANK_W];
    bank_oh          = '0;
    bank_oh[xfer_bank] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Registered SRAM strobes; address and write data hold when idle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sram_cs        <= '0;
      sram_r_trigger <= '0;
      sram_w_trigger <= '0;
      sram_addr      <= '0;
      sram_wdata     <= '0;
    end else begin
      sram_cs        <= xfer ? bank_oh : '0;
      sram_r_trigger <= (xfer && !req_write[xfer_id]) ? bank_oh : '0;
      sram_w_trigger <= (xfer &&  req_write[xfer_id]) ? bank_oh : '0;
      if (xfer) begin
        sram_addr  <= req_addr[xfer_id*ADDR_W +: ADDR_W];
        sram_wdata <= req_wdata[xfer_id*DATA_W +: DATA_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read-return pipeline: stage k is valid during strobe cycle + k. The last
  // stage selects the bank whose data is present this cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      // NOTE: the tag pipeline is cleared on reset, not left to flush, so a
      // read in flight at reset can never surface as a response afterwards.
      for (int k = 0; k <= RD_LAT; k++) pipe_q[k] <= '0;
    end else begin
      pipe_q[0] <= '{valid: xfer && !req_write[xfer_id], id: xfer_id, bank: xfer_bank};
      for (int k = 1; k <= RD_LAT; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= '0;
      if (pipe_q[RD_LAT].valid) begin
        rsp_valid[pipe_q[RD_LAT].id] <= 1'b1;
        rsp_data <= sram_rdata[pipe_q[RD_LAT].bank*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int k = 0; k <= RD_LAT; k++) pipe_busy = pipe_busy | pipe_q[k].valid;
  end

  assign busy = n_rst & ((|req_valid) | pipe_busy);

endmodule

// File: tb/tb_sram_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_access_arbiter
// Drives the arbiter with directed and random request traffic, models the
// SRAM banks, and compares every cycle against a behavioural reference built
// from the arbitration rules (round-robin pointer, lock owner, burst count,
// queue of expected read responses with due cycle).
// -----------------------------------------------------------------------------
module tb_sram_access_arbiter;

  localparam int NR   = 3;
  localparam int NB   = 8;
  localparam int AW   = 10;
  localparam int DW   = 64;
  localparam int RDL  = 1;
  localparam int MAXB = 16;

  logic             clk = 1'b0;
  logic             n_rst;
  logic [NR-1:0]    req_valid, req_write, req_lock, req_ready;
  logic [NR*3-1:0]  req_bank;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NB-1:0]    sram_cs, sram_r_trigger, sram_w_trigger;
  logic [AW-1:0]    sram_addr;
  logic [DW-1:0]    sram_wdata, rsp_data;
  logic [NB*DW-1:0] sram_rdata;
  logic [NR-1:0]    rsp_valid;
  logic             busy;

  sram_access_arbiter #(.RD_LAT(RDL), .MAX_BURST(MAXB)) dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_write(req_write), .req_lock(req_lock),
    .req_bank(req_bank), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .sram_cs(sram_cs), .sram_r_trigger(sram_r_trigger), .sram_w_trigger(sram_w_trigger),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Per-port stimulus state
  logic [NR-1:0] tv, tw, tl;
  logic [2:0]    tbk [NR];
  logic [AW-1:0] ta  [NR];
  logic [DW-1:0] td  [NR];

  // SRAM environment memory and reference memory
  logic [DW-1:0] sram_mem [NB][1024];
  logic [DW-1:0] ref_mem  [NB][1024];
  int            pend_bank;
  logic [DW-1:0] pend_data;

  // Reference model state
  int            m_rr, m_owner, m_burst, cyc, last_g;
  logic [NB-1:0] e_cs, e_r, e_w;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  typedef struct { int due; int port; logic [DW-1:0] data; } rsp_t;
  rsp_t rq [$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic drive();
    req_valid = tv; req_write = tw; req_lock = tl;
    for (int i = 0; i < NR; i++) begin
      req_bank[i*3 +: 3]    = tbk[i];
      req_addr[i*AW +: AW]  = ta[i];
      req_wdata[i*DW +: DW] = td[i];
    end
  endtask

  task automatic drive_rdata();
    for (int b = 0; b < NB; b++) sram_rdata[b*DW +: DW] = {$urandom, $urandom};
    if (pend_bank >= 0) sram_rdata[pend_bank*DW +: DW] = pend_data;
    pend_bank = -1;
  endtask

  task automatic new_req(int p, bit allow_lock);
    tv[p]  = 1'b1;
    tw[p]  = 1'($urandom % 2);
    tl[p]  = allow_lock ? 1'($urandom % 4 != 0) : 1'b0;
    tbk[p] = 3'($urandom % 8);
    ta[p]  = AW'($urandom % 16);
    td[p]  = {$urandom, $urandom};
  endtask

  task automatic model_reset();
    m_rr = 0; m_owner = -1; m_burst = 0; last_g = -1;
    e_cs = '0; e_r = '0; e_w = '0; e_addr = '0; e_wdata = '0;
    rq.delete(); pend_bank = -1;
  endtask

  function automatic int pick();
    if (m_owner >= 0) return tv[m_owner] ? m_owner : -1;
    for (int k = 0; k < NR; k++) if (tv[(m_rr + k) % NR]) return (m_rr + k) % NR;
    return -1;
  endfunction

  // One clock cycle: compare at the falling edge, then advance the model.
  task automatic tick();
    int g;
    logic [NR-1:0] e_ready, e_rv;
    logic [DW-1:0] e_rd;
    logic e_busy;
    drive();
    @(negedge clk);
    g = pick();
    e_ready = (g >= 0) ? NR'(1 << g) : '0;
    n_checks++;
    if (req_ready !== e_ready) $display("FAIL ready cyc %0d: got %b exp %b", cyc, req_ready, e_ready);
    else n_pass++;
    n_checks++;
    if ({sram_cs, sram_r_trigger, sram_w_trigger} !== {e_cs, e_r, e_w})
      $display("FAIL strobes cyc %0d: got cs=%h r=%h w=%h exp cs=%h r=%h w=%h",
               cyc, sram_cs, sram_r_trigger, sram_w_trigger, e_cs, e_r, e_w);
    else n_pass++;
    n_checks++;
    if ({sram_addr, sram_wdata} !== {e_addr, e_wdata})
      $display("FAIL addr_wdata cyc %0d: got %h/%h exp %h/%h", cyc, sram_addr, sram_wdata, e_addr, e_wdata);
    else n_pass++;
    e_rv = '0; e_rd = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e_rv = NR'(1 << rq[0].port); e_rd = rq[0].data;
      void'(rq.pop_front());
    end
    n_checks++;
    if (rsp_valid !== e_rv) $display("FAIL rsp_valid cyc %0d: got %b exp %b", cyc, rsp_valid, e_rv);
    else n_pass++;
    if (e_rv != '0) begin
      n_checks++;
      if (rsp_data !== e_rd) $display("FAIL rsp_data cyc %0d: got %h exp %h", cyc, rsp_data, e_rd);
      else n_pass++;
    end
    e_busy = |tv;
    foreach (rq[j]) if (rq[j].due > cyc) e_busy = 1'b1;
    n_checks++;
    if (busy !== e_busy) $display("FAIL busy cyc %0d: got %b exp %b", cyc, busy, e_busy);
    else n_pass++;

    // SRAM environment reacts to the strobes actually present.
    for (int b = 0; b < NB; b++) begin
      if (sram_w_trigger[b]) sram_mem[b][sram_addr] = sram_wdata;
      if (sram_r_trigger[b]) begin pend_bank = b; pend_data = sram_mem[b][sram_addr]; end
    end

    // Reference model advance.
    e_cs = '0; e_r = '0; e_w = '0;
    if (g >= 0) begin
      e_cs[tbk[g]] = 1'b1;
      if (tw[g]) begin e_w[tbk[g]] = 1'b1; ref_mem[tbk[g]][ta[g]] = td[g]; end
      else begin
        e_r[tbk[g]] = 1'b1;
        rq.push_back('{due: cyc + 2 + RDL, port: g, data: ref_mem[tbk[g]][ta[g]]});
      end
      e_addr = ta[g]; e_wdata = td[g];
    end
    if (m_owner >= 0 && !tv[m_owner]) begin
      m_rr = (m_owner + 1) % NR; m_owner = -1;
    end else if (g >= 0) begin
      m_rr = (g + 1) % NR;
      if (m_owner < 0) begin
        if (tl[g] && MAXB > 1) begin m_owner = g; m_burst = 1; end
      end else begin
        m_burst++;
        if (!tl[g] || m_burst == MAXB) m_owner = -1;
      end
    end
    last_g = g;
    @(posedge clk); #1;
    cyc++;
    drive_rdata();
  endtask

  task automatic idle(int n);
    tv = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    tv = 3'b111; tw = '0; tl = '0;
    for (int i = 0; i < NR; i++) begin tbk[i] = '0; ta[i] = '0; td[i] = '0; end
    drive();
    n_rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 3'b000) $display("FAIL reset_ready: got %b exp 000", req_ready); else n_pass++;
    n_checks++;
    if ({sram_cs, sram_r_trigger, sram_w_trigger, rsp_valid} !== '0)
      $display("FAIL reset_strobes: got %h exp 0", {sram_cs, sram_r_trigger, sram_w_trigger, rsp_valid});
    else n_pass++;
    n_checks++;
    if ({sram_addr, sram_wdata, rsp_data, busy} !== '0)
      $display("FAIL reset_data: got %h exp 0", {sram_addr, sram_wdata, rsp_data, busy});
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    tv = '0; drive();
    model_reset(); drive_rdata();
    n_rst = 1'b1;
    idle(2);
  endtask

  task automatic test_write_read();
    tv = 3'b001; tw[0] = 1'b1; tl[0] = 1'b0; tbk[0] = 3'd3; ta[0] = 10'h155;
    td[0] = 64'hDEAD_BEEF_00C0_FFEE;
    tick();
    tv[0] = 1'b0; drive();
    n_checks++;
    if ({sram_cs, sram_w_trigger, sram_r_trigger} !== {8'h08, 8'h08, 8'h00})
      $display("FAIL wr_strobe: got cs=%h w=%h r=%h exp 08/08/00", sram_cs, sram_w_trigger, sram_r_trigger);
    else n_pass++;
    n_checks++;
    if ({sram_addr, sram_wdata} !== {10'h155, 64'hDEAD_BEEF_00C0_FFEE})
      $display("FAIL wr_addr: got %h/%h exp 155/deadbeef00c0ffee", sram_addr, sram_wdata);
    else n_pass++;
    tv[2] = 1'b1; tw[2] = 1'b0; tl[2] = 1'b0; tbk[2] = 3'd3; ta[2] = 10'h155; td[2] = '0;
    tick();
    tv[2] = 1'b0;
    tick(); tick();
    n_checks++;
    if (rsp_valid !== 3'b100 || rsp_data !== 64'hDEAD_BEEF_00C0_FFEE)
      $display("FAIL rd_back: got %b/%h exp 100/deadbeef00c0ffee", rsp_valid, rsp_data);
    else n_pass++;
    idle(2);
  endtask

  task automatic test_round_robin();
    for (int p = 0; p < NR; p++) new_req(p, 1'b0);
    for (int k = 0; k < 6; k++) begin
      drive(); #1;
      n_checks++;
      if (req_ready !== NR'(1 << (k % NR)))
        $display("FAIL rr_order step %0d: got %b exp %b", k, req_ready, NR'(1 << (k % NR)));
      else n_pass++;
      tick();
      if (last_g >= 0) new_req(last_g, 1'b0);
    end
    idle(4);
  endtask

  task automatic test_lock_burst();
    int run;
    new_req(0, 1'b0);
    tick();                                  // port0 alone: pointer moves to 1
    new_req(0, 1'b0);
    new_req(1, 1'b0); tl[1] = 1'b1;
    run = 0;
    for (int k = 0; k < MAXB; k++) begin
      drive(); #1;
      if (req_ready === 3'b010) run++;
      tick();
      new_req(1, 1'b0); tl[1] = 1'b1;
    end
    n_checks++;
    if (run != MAXB) $display("FAIL lock_run: got %0d exp %0d", run, MAXB); else n_pass++;
    drive(); #1;
    n_checks++;
    if (req_ready !== 3'b001) $display("FAIL lock_exit: got %b exp 001", req_ready); else n_pass++;
    tick();
    tv[0] = 1'b0;
    drive(); #1;
    n_checks++;
    if (req_ready !== 3'b010) $display("FAIL lock_regrant: got %b exp 010", req_ready); else n_pass++;
    tick();
    idle(4);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d5, d6;
    d5 = ref_mem[5][10'h20];
    d6 = ref_mem[6][10'h21];
    tv = 3'b001; tw[0] = 1'b0; tl[0] = 1'b0; tbk[0] = 3'd5; ta[0] = 10'h20;
    tick();
    tv = 3'b010; tw[1] = 1'b0; tl[1] = 1'b0; tbk[1] = 3'd6; ta[1] = 10'h21;
    tick();
    tv = 3'b000;
    tick();
    n_checks++;
    if (rsp_valid !== 3'b001 || rsp_data !== d5)
      $display("FAIL b2b_first: got %b/%h exp 001/%h", rsp_valid, rsp_data, d5);
    else n_pass++;
    tick();
    n_checks++;
    if (rsp_valid !== 3'b010 || rsp_data !== d6)
      $display("FAIL b2b_second: got %b/%h exp 010/%h", rsp_valid, rsp_data, d6);
    else n_pass++;
    idle(3);
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      for (int p = 0; p < NR; p++) if (!tv[p] && ($urandom % 2 == 0)) new_req(p, 1'b1);
      tick();
      if (last_g >= 0) begin
        if ($urandom % 4 == 0) tv[last_g] = 1'b0;
        else new_req(last_g, 1'b1);
      end
    end
    idle(6);
  endtask

  task automatic test_reset_inflight();
    tv = 3'b001; tw[0] = 1'b0; tl[0] = 1'b0; tbk[0] = 3'd2; ta[0] = 10'h7;
    tick();                                  // read issued; now in strobe cycle
    tv = '0; drive();
    n_rst = 1'b0;
    #1;
    n_checks++;
    if ({sram_cs, sram_r_trigger, rsp_valid, busy} !== '0)
      $display("FAIL inflight_reset: got %h exp 0", {sram_cs, sram_r_trigger, rsp_valid, busy});
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    model_reset(); drive_rdata();
    n_rst = 1'b1;
    idle(5);
    for (int p = 0; p < NR; p++) new_req(p, 1'b0);
    drive(); #1;
    n_checks++;
    if (req_ready !== 3'b001) $display("FAIL post_reset_grant: got %b exp 001", req_ready); else n_pass++;
    tick();
    idle(4);
  endtask

  initial begin
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 1024; a++) begin
        sram_mem[b][a] = {$urandom, $urandom};
        ref_mem[b][a]  = sram_mem[b][a];
      end
    cyc = 0;
    model_reset();
    drive_rdata();
    test_reset();
    test_write_read();
    test_round_robin();
    test_lock_burst();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_access_arbiter.md
SRAM_ACCESS_ARBITER -- requirements
Module: sram_access_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ=3 (requester ports); NUM_BANKS=8 (SRAM banks); ADDR_W=10 (word address); DATA_W=64 (word width); RD_LAT=1 (SRAM cycles from read trigger to valid read data); MAX_BURST=16 (max consecutive locked grants).
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock.
- n_rst  in  1  async active-low reset.
- req_valid  in  NUM_REQ  request pending per port.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_lock  in  NUM_REQ  hold grant for a burst.
- req_bank  in  NUM_REQ x 3  target bank.
- req_addr  in  NUM_REQ x ADDR_W  word address.
- req_wdata  in  NUM_REQ x DATA_W  write data.
- req_ready  out  NUM_REQ  grant; transfer occurs when valid and ready are both high at a clock edge.
- sram_cs  out  NUM_BANKS  one-hot bank select.
- sram_r_trigger  out  NUM_BANKS  read strobe.
- sram_w_trigger  out  NUM_BANKS  write strobe.
- sram_addr  out  ADDR_W  address.
- sram_wdata  out  DATA_W  write data.
- sram_rdata  in  NUM_BANKS x DATA_W  per-bank read data.
- rsp_valid  out  NUM_REQ  read response strobe, routed to the issuing port.
- rsp_data  out  DATA_W  read response data.
- busy  out  1  transaction in flight or any req_valid high.

Function
REQ-004 Each cycle, at most one req_ready bit SHALL be high, and only for a port whose req_valid is high.
REQ-005 In ARB state, the winner SHALL be the first valid port searched cyclically from rr_ptr; req_ready is combinational from the current state and req_valid.
REQ-006 On a transfer by port i, rr_ptr SHALL become (i+1) mod NUM_REQ; rr_ptr resets to 0.
REQ-007 A transfer in cycle N SHALL produce registered SRAM strobes during cycle N+1 only: sram_cs and exactly one of r/w_trigger one-hot on req_bank; sram_addr and sram_wdata from the granted port.
REQ-008 When no transfer occurs, all cs/trigger bits SHALL be 0 in the following cycle; sram_addr and sram_wdata SHALL hold their previous values.
REQ-009 A read issued in strobe cycle T SHALL have its data taken from sram_rdata[bank] in cycle T+RD_LAT, then registered to rsp_data with rsp_valid[i] high for exactly cycle T+RD_LAT+1 (N+3 for RD_LAT=1).
REQ-010 Issue bank and port ID SHALL be carried in a RD_LAT+1 deep pipeline so back-to-back reads, one per cycle from any mix of ports, return in issue order with no bubbles.
REQ-011 Writes SHALL produce no rsp_valid.
REQ-012 The FSM SHALL have states ARB and LOCKED.
REQ-013 ARB -> LOCKED SHALL occur on a transfer with req_lock[i]=1; the owner is i and burst_cnt is set to 1.
REQ-014 In LOCKED, only the owner SHALL be eligible; each owner transfer increments burst_cnt.
REQ-015 LOCKED -> ARB SHALL occur when any of these holds: the owner's req_valid is 0; the owner transfers with req_lock=0; burst_cnt reaches MAX_BURST. After such an exit, rr_ptr = owner+1.
REQ-016 In LOCKED, other ports' req_valid SHALL be ignored (ready low) and their requests held; no request is dropped.
REQ-017 busy SHALL be high whenever any req_valid is high or the read pipeline holds an entry.

Reset
REQ-018 On n_rst low, outputs SHALL immediately be: req_ready, sram_cs, r/w_trigger and rsp_valid = 0; sram_addr, sram_wdata and rsp_data = 0; busy = 0. State SHALL be ARB, rr_ptr = 0, burst_cnt = 0, read pipeline cleared.
REQ-019 Reads in flight at reset SHALL never produce rsp_valid after reset release.

Structure
REQ-020 Package sram_arb_pkg SHALL hold NUM_REQ, NUM_BANKS, ADDR_W, DATA_W, the req_id_t and bank_t typedefs, and the arb_state_t enum {ARB, LOCKED}.
REQ-021 Round-robin selection SHALL live in one sub-module, sram_rr_select (valid vector + pointer -> one-hot grant); all other logic is in the top module.

Verification
REQ-022 Reset -> all outputs 0. Then a port0 write at bank 3, addr 0x155, data 0xDEADBEEF00C0FFEE -> cycle N+1 cs=0x08, w_trigger=0x08, addr=0x155; no rsp_valid.
REQ-023 Port2 read at bank 3, addr 0x155 after the REQ-022 write -> rsp_valid=3'b100 at N+3, rsp_data=0xDEADBEEF00C0FFEE.
REQ-024 All three ports hold req_valid continuously (no lock) -> grants 0,1,2,0,1,2; never two readies in one cycle.
REQ-025 Port1 holds req_lock with port0 valid throughout -> 16 consecutive port1 grants, then port0 granted; port1 next grantable after port2/port0 rotation.
REQ-026 Reads issued by port0 in one cycle and port1 in the next, banks 5 and 6 -> rsp_valid 001 then 010 on consecutive cycles with the correct per-bank data.
REQ-027 n_rst asserted one cycle after a read issue -> no rsp_valid ever appears; after release, the first grant goes to port0.
